// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master with one-hot chip selects
// SCK is produced by a clk-enable half-period counter; all outputs are registered.
module spi_master_param #(
    parameter int DATA_W   = 8,
    parameter int NUM_CS   = 4,
    parameter int DIV_W    = 8,
    parameter int CSS_CYC  = 3,
    parameter int CSH_CYC  = 5,
    parameter int CS_SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                continued_i,
    input  logic [CS_SEL_W-1:0] cs_sel_i,
    input  logic [DIV_W-1:0]    clk_div_i,
    input  logic                cpol_i,
    input  logic                cpha_i,
    input  logic                lsb_first_i,
    input  logic [DATA_W-1:0]   tx_data_i,
    output logic [DATA_W-1:0]   rx_data_o,
    output logic                rx_valid_o,
    output logic                ready_o,
    output logic                sck_o,
    output logic [NUM_CS-1:0]   cs_n_o,
    output logic                mosi_o,
    input  logic                miso_i
);
    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);
    localparam int TMAX  = (CSS_CYC > CSH_CYC) ? CSS_CYC : CSH_CYC;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d, rx_data_q, rx_data_d;
    logic [DIV_W-1:0]    div_q, div_d, cnt_q, cnt_d;
    logic [EW-1:0]       edge_q, edge_d, edge_nxt;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [CS_SEL_W-1:0] sel_q, sel_d, held_q, held_d;
    logic                held_vld_q, held_vld_d, pend_q, pend_d;
    logic                cont_q, cont_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic                sck_q, sck_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d, ready_q, ready_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                out_bit;
    logic [DATA_W-1:0]   sr_shift;

    function automatic logic [NUM_CS-1:0] sel_to_cs_n(input logic [CS_SEL_W-1:0] sel);
        logic [NUM_CS-1:0] r;
        for (int i = 0; i < NUM_CS; i++) r[i] = (int'(sel) != i);
        return r;
    endfunction

    // One register both shifts bits out and collects miso, so rx ends in transmit order.
    assign out_bit  = lsb_q ? sr_q[0] : sr_q[DATA_W-1];
    assign sr_shift = lsb_q ? {miso_i, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], miso_i};
    assign edge_nxt = edge_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        rx_data_d  = rx_data_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        tmr_d      = tmr_q;
        sel_d      = sel_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        pend_d     = pend_q;
        cont_d     = cont_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                sck_d  = cpol_i;
                mosi_d = 1'b1;
                if (start_i) begin
                    sr_d   = tx_data_i;
                    div_d  = clk_div_i;
                    cont_d = continued_i;
                    cpha_d = cpha_i;
                    lsb_d  = lsb_first_i;
                    sel_d  = cs_sel_i;
                    if (!held_vld_q) begin
                        state_d = SETUP;
                        tmr_d   = TW'(CSS_CYC - 1);
                        cs_n_d  = sel_to_cs_n(cs_sel_i);
                    end else if (cs_sel_i == held_q) begin
                        state_d = SHIFT;
                        cnt_d   = clk_div_i;
                        edge_d  = '0;
                        if (!cpha_i) mosi_d = lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_W-1];
                    end else begin
                        // Different slave while CS held: release the old one first.
                        state_d = HOLD;
                        tmr_d   = TW'(CSH_CYC - 1);
                        pend_d  = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (tmr_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = div_q;
                    edge_d  = '0;
                    if (!cpha_q) mosi_d = out_bit;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SHIFT: begin
                if (edge_q == EW'(EDGES)) begin
                    rx_data_d  = sr_q;
                    rx_valid_d = 1'b1;
                    mosi_d     = 1'b1;
                    if (cont_q) begin
                        state_d    = IDLE;
                        held_vld_d = 1'b1;
                        held_d     = sel_q;
                    end else begin
                        state_d = HOLD;
                        tmr_d   = TW'(CSH_CYC - 1);
                    end
                end else if (cnt_q == '0) begin
                    cnt_d  = div_q;
                    sck_d  = ~sck_q;
                    edge_d = edge_nxt;
                    if (edge_nxt[0] ^ cpha_q) sr_d = sr_shift;
                    else if (edge_nxt != EW'(EDGES)) mosi_d = out_bit;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (tmr_q == '0) begin
                    state_d    = GAP;
                    cs_n_d     = '1;
                    held_vld_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GAP: begin
                if (pend_q) begin
                    state_d = SETUP;
                    pend_d  = 1'b0;
                    tmr_d   = TW'(CSS_CYC - 1);
                    cs_n_d  = sel_to_cs_n(sel_q);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            rx_data_q  <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            tmr_q      <= '0;
            sel_q      <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            cont_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b1;
            cs_n_q     <= '1;
            rx_valid_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            rx_data_q  <= rx_data_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tmr_q      <= tmr_d;
            sel_q      <= sel_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            pend_q     <= pend_d;
            cont_q     <= cont_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_valid_q <= rx_valid_d;
            ready_q    <= ready_d;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign ready_o    = ready_q;
    assign sck_o      = sck_q;
    assign cs_n_o     = cs_n_q;
    assign mosi_o     = mosi_q;
endmodule
